noc_output_port: RTL and testbench
==================================

NOC_OUTPUT_PORT -- requirements
Module: noc_output_port

Interface
- REQ-001: NUM_IN, default 5, number of upstream input blocks (local, N, E, S, W) competing for this port.
- REQ-002: CHANNELS, default 2, number of virtual channels (VCs) on the link; VC_W = max(1, clog2(CHANNELS)).
- REQ-003: FLIT_W, default 64, flit payload width.
- REQ-004: CREDITS, default 4, downstream per-VC FIFO depth; CR_W = clog2(CREDITS+1).
- REQ-005: One clock; reset is synchronous and active-high. noc_clk and noc_rst are named accordingly.
- REQ-006: noc_clk  in  1  sole clock; all state updates on rising edge.
- REQ-007: noc_rst  in  1  synchronous, active-high reset.
- REQ-008: in_valid  in  NUM_IN  per-input flit offer.
- REQ-009: in_vc  in  NUM_IN*VC_W  per-input target VC.
- REQ-010: in_head  in  NUM_IN  per-input head-flit flag.
- REQ-011: in_tail  in  NUM_IN  per-input tail-flit flag (head&tail = single-flit packet).
- REQ-012: in_flit  in  NUM_IN*FLIT_W  per-input payload.
- REQ-013: in_ready  out  NUM_IN  grant; transfer when in_valid[i]&in_ready[i].
- REQ-014: out_valid  out  1  registered flit strobe to link.
- REQ-015: out_vc, out_head, out_tail, out_flit  out  VC_W/1/1/FLIT_W  registered flit fields.
- REQ-016: credit_valid  in  1  downstream freed one slot.
- REQ-017: credit_vc  in  VC_W  VC of returned credit.
- REQ-018: proto_err  out  1  sticky protocol-error flag.

Function
- REQ-019: Per VC v, credit counter cnt[v] (CR_W bits) tracks free downstream slots.
- REQ-020: Per VC v, lock state: IDLE, or OWNED(i) recording owner input i.
- REQ-021: Input i eligible when in_valid[i], cnt[in_vc[i]]>0, and either lock[in_vc[i]] is IDLE with in_head[i]=1, or lock[in_vc[i]] is OWNED(i).
- REQ-022: At most one grant per cycle, round-robin among eligible inputs, search starting at pointer rr.
- REQ-023: On grant to i, rr becomes (i+1) mod NUM_IN; with no grant, rr holds.
- REQ-024: in_ready is combinational from current state and inputs; one-hot or zero.
- REQ-025: Granted flit appears on out_* exactly one cycle later with out_valid=1; no grant gives out_valid=0 next cycle and out_* fields hold.
- REQ-026: Lock transitions on grant of i on VC v: IDLE->OWNED(i) if head&!tail; OWNED(i)->IDLE if tail; head&tail leaves IDLE.
- REQ-027: Credit update per VC: send only, cnt-1; credit only, cnt+1; both in same cycle on same VC, unchanged.
- REQ-028: A credit return with cnt[credit_vc]==CREDITS (no send that cycle) saturates and sets proto_err.
- REQ-029: A head flit offered by the owner on an OWNED VC, or a non-head flit on an IDLE VC, is never granted and sets proto_err.
- REQ-030: Other VCs and inputs continue arbitrating while one input is stalled (no head-of-line coupling across VCs).
- REQ-031: cnt[v]==0 blocks all grants on v until a credit returns. A credit arriving in cycle t enables a grant in cycle t+1.
- REQ-032: The port has no output back-pressure; credits are the only flow control.

Reset
- REQ-033: While noc_rst=1 at an edge: cnt[v]=CREDITS for all v, all locks IDLE, rr=0, out_valid=0, out_* fields=0, proto_err=0.
- REQ-034: Reset mid-packet discards lock ownership and in-flight state. in_ready is forced to 0 during a reset cycle.

Verification
- REQ-035: Single-flit packet on input 2, VC 1 (head=tail=1), idle port -> in_ready[2]=1 same cycle; next cycle out_valid=1, out_vc=1, cnt[1]=CREDITS-1, lock stays IDLE.
- REQ-036: Inputs 0 and 3 both offer heads on VC 0, rr=0 -> 0 granted and owns VC 0. Input 3 is blocked until 0's tail is sent, then 3 is granted.
- REQ-037: CREDITS=4, no credit returns, 5-flit packet on VC 0 -> 4 flits sent, then in_ready=0. credit_valid on VC 0 -> 5th flit granted the following cycle.
- REQ-038: Send and credit return on VC 1 in the same cycle with cnt=2 -> cnt remains 2. Credit return with cnt=4 -> proto_err=1, cnt stays 4.
- REQ-039: Input 1 holds VC 0 mid-packet while input 4 offers a head on VC 1 -> input 4 is granted in round-robin turn, and both packets interleave on out_vc correctly.
- REQ-040: noc_rst asserted mid-packet -> next cycle out_valid=0, all cnt=CREDITS, locks IDLE, proto_err=0, and a new head is accepted after reset deasserts.

Source files
------------

// File: rtl/noc_output_port_if.sv
// Link-side bundle of the NoC output port: flit offers from the upstream
// input blocks, the registered flit toward the link, and the returned credits.
interface noc_output_port_if #(
    parameter int NUM_IN   = 5,
    parameter int CHANNELS = 2,
    parameter int FLIT_W   = 64
);
    localparam int VC_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [NUM_IN-1:0]        in_valid;
    logic [NUM_IN*VC_W-1:0]   in_vc;
    logic [NUM_IN-1:0]        in_head;
    logic [NUM_IN-1:0]        in_tail;
    logic [NUM_IN*FLIT_W-1:0] in_flit;
    logic [NUM_IN-1:0]        in_ready;

    logic                     out_valid;
    logic [VC_W-1:0]          out_vc;
    logic                     out_head;
    logic                     out_tail;
    logic [FLIT_W-1:0]        out_flit;

    logic                     credit_valid;
    logic [VC_W-1:0]          credit_vc;
    logic                     proto_err;

    // The output port itself.
    modport slave (
        input  in_valid, in_vc, in_head, in_tail, in_flit, credit_valid, credit_vc,
        output in_ready, out_valid, out_vc, out_head, out_tail, out_flit, proto_err
    );

    // Upstream inputs plus the downstream link partner.
    modport master (
        output in_valid, in_vc, in_head, in_tail, in_flit, credit_valid, credit_vc,
        input  in_ready, out_valid, out_vc, out_head, out_tail, out_flit, proto_err
    );
endinterface

// File: rtl/noc_output_port.sv
// NoC output port: round-robin arbitration of NUM_IN inputs onto one link,
// per-VC wormhole locking and per-VC credit-based flow control.
module noc_output_port #(
    parameter int NUM_IN   = 5,
    parameter int CHANNELS = 2,
    parameter int FLIT_W   = 64,
    parameter int CREDITS  = 4
) (
    input  logic              noc_clk,
    input  logic              noc_rst,
    noc_output_port_if.slave  port
);
    localparam int VC_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int CR_W = $clog2(CREDITS + 1);
    localparam int IN_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    // Tables cover every encodable VC; entries beyond CHANNELS keep zero
    // credits forever, so flits addressed to them are never granted.
    localparam int VC_N = 1 << VC_W;

    typedef enum logic { LK_IDLE, LK_OWNED } lock_e;

    lock_e             lock_q  [VC_N];
    lock_e             lock_d  [VC_N];
    logic [IN_W-1:0]   owner_q [VC_N];
    logic [IN_W-1:0]   owner_d [VC_N];
    logic [CR_W-1:0]   cnt_q   [VC_N];
    logic [CR_W-1:0]   cnt_d   [VC_N];
    logic [IN_W-1:0]   rr_q, rr_d;
    logic              err_q, err_d;

    logic              out_valid_q;
    logic [VC_W-1:0]   out_vc_q;
    logic              out_head_q;
    logic              out_tail_q;
    logic [FLIT_W-1:0] out_flit_q;

    logic [VC_W-1:0]   vc_of [NUM_IN];
    logic [NUM_IN-1:0] elig;
    logic [NUM_IN-1:0] viol;
    logic [NUM_IN-1:0] gnt;
    logic              gnt_any;
    logic [IN_W-1:0]   gnt_idx;
    logic [VC_W-1:0]   sel_vc;
    logic              sel_head;
    logic              sel_tail;
    logic [FLIT_W-1:0] sel_flit;

    // Eligibility, protocol checks, round-robin pick and granted-flit mux.
    always_comb begin
        // NOTE: every output of this block gets a default before any branch,
        // so no path can leave a value held and infer a latch.
        elig     = '0;
        viol     = '0;
        gnt      = '0;
        gnt_any  = 1'b0;
        gnt_idx  = '0;
        sel_vc   = '0;
        sel_head = 1'b0;
        sel_tail = 1'b0;
        sel_flit = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            vc_of[i] = port.in_vc[i*VC_W +: VC_W];
        end

        for (int i = 0; i < NUM_IN; i++) begin
            if (port.in_valid[i]) begin
                if (lock_q[vc_of[i]] == LK_IDLE) begin
                    elig[i] = port.in_head[i] && (cnt_q[vc_of[i]] != '0);
                    viol[i] = !port.in_head[i];
                end else if (owner_q[vc_of[i]] == IN_W'(i)) begin
                    elig[i] = !port.in_head[i] && (cnt_q[vc_of[i]] != '0);
                    viol[i] = port.in_head[i];
                end
            end
        end

        // First pass finds the lowest eligible index at or above rr; the
        // second pass wraps around to the lowest eligible index overall.
        for (int i = 0; i < NUM_IN; i++) begin
            if (!gnt_any && elig[i] && (i >= int'(rr_q))) begin
                gnt_any = 1'b1;
                gnt_idx = IN_W'(i);
            end
        end
        for (int i = 0; i < NUM_IN; i++) begin
            if (!gnt_any && elig[i]) begin
                gnt_any = 1'b1;
                gnt_idx = IN_W'(i);
            end
        end

        for (int i = 0; i < NUM_IN; i++) begin
            if (gnt_any && (gnt_idx == IN_W'(i))) begin
                gnt[i]   = 1'b1;
                sel_vc   = vc_of[i];
                sel_head = port.in_head[i];
                sel_tail = port.in_tail[i];
                sel_flit = port.in_flit[i*FLIT_W +: FLIT_W];
            end
        end
    end

    // Next-state for credits, VC locks, arbitration pointer and error flag.
    always_comb begin
        cnt_d   = cnt_q;
        lock_d  = lock_q;
        owner_d = owner_q;
        err_d   = err_q | (|viol);
        rr_d    = rr_q;
        if (gnt_any) begin
            rr_d = (gnt_idx == IN_W'(NUM_IN - 1)) ? '0 : gnt_idx + 1'b1;
        end

        for (int v = 0; v < CHANNELS; v++) begin
            if (gnt_any && (sel_vc == VC_W'(v))) begin
                // A credit returned on the same VC in the same cycle cancels
                // the send's decrement.
                if (!(port.credit_valid && (port.credit_vc == VC_W'(v)))) begin
                    cnt_d[v] = cnt_q[v] - 1'b1;
                end
                if ((lock_q[v] == LK_IDLE) && !sel_tail) begin
                    lock_d[v]  = LK_OWNED;
                    owner_d[v] = gnt_idx;
                end else if ((lock_q[v] == LK_OWNED) && sel_tail) begin
                    lock_d[v] = LK_IDLE;
                end
            end else if (port.credit_valid && (port.credit_vc == VC_W'(v))) begin
                // More credits than slots means the downstream miscounted.
                if (cnt_q[v] == CR_W'(CREDITS)) begin
                    err_d = 1'b1;
                end else begin
                    cnt_d[v] = cnt_q[v] + 1'b1;
                end
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge noc_clk) begin
        if (noc_rst) begin
            // NOTE: the per-VC tables are reset explicitly because the credit
            // counts and locks must be valid on the first cycle out of reset.
            for (int v = 0; v < VC_N; v++) begin
                cnt_q[v]   <= (v < CHANNELS) ? CR_W'(CREDITS) : '0;
                lock_q[v]  <= LK_IDLE;
                owner_q[v] <= '0;
            end
            rr_q        <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_vc_q    <= '0;
            out_head_q  <= 1'b0;
            out_tail_q  <= 1'b0;
            out_flit_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // the pre-edge values computed by the combinational blocks.
            cnt_q       <= cnt_d;
            lock_q      <= lock_d;
            owner_q     <= owner_d;
            rr_q        <= rr_d;
            err_q       <= err_d;
            out_valid_q <= gnt_any;
            if (gnt_any) begin
                out_vc_q   <= sel_vc;
                out_head_q <= sel_head;
                out_tail_q <= sel_tail;
                out_flit_q <= sel_flit;
            end
        end
    end

    assign port.in_ready  = noc_rst ? '0 : gnt;
    assign port.out_valid = out_valid_q;
    assign port.out_vc    = out_vc_q;
    assign port.out_head  = out_head_q;
    assign port.out_tail  = out_tail_q;
    assign port.out_flit  = out_flit_q;
    assign port.proto_err = err_q;

endmodule

// File: tb/tb_noc_output_port.sv
// Self-checking bench for noc_output_port: directed scenarios followed by
// randomized legal traffic, all compared against a packet-level model.
module tb_noc_output_port;
    localparam int NUM_IN   = 5;
    localparam int CHANNELS = 2;
    localparam int FLIT_W   = 64;
    localparam int CREDITS  = 4;
    localparam int VC_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    noc_output_port_if #(.NUM_IN(NUM_IN), .CHANNELS(CHANNELS), .FLIT_W(FLIT_W)) bus ();

    noc_output_port #(
        .NUM_IN(NUM_IN), .CHANNELS(CHANNELS), .FLIT_W(FLIT_W), .CREDITS(CREDITS)
    ) dut (
        .noc_clk (clk),
        .noc_rst (rst),
        .port    (bus.slave)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Driven offers (one per input) and the credit return.
    bit          d_valid [NUM_IN];
    int          d_vc    [NUM_IN];
    bit          d_head  [NUM_IN];
    bit          d_tail  [NUM_IN];
    logic [63:0] d_flit  [NUM_IN];
    bit          cr_valid;
    int          cr_vc;

    // Reference model: free slots per VC, owning input per VC (-1 = idle).
    int          m_cnt [CHANNELS];
    int          m_own [CHANNELS];
    int          m_rr;
    bit          m_err;
    bit          e_valid, e_head, e_tail;
    int          e_vc;
    logic [63:0] e_flit;

    // Random traffic generator and downstream occupancy.
    bit          rand_mode = 1'b0;
    int          p_left  [NUM_IN];
    int          p_vc    [NUM_IN];
    bit          p_first [NUM_IN];
    logic [63:0] p_flit  [NUM_IN];
    int          down_occ [CHANNELS];

    logic [NUM_IN-1:0] last_ready;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clr();
        for (int i = 0; i < NUM_IN; i++) begin
            d_valid[i] = 1'b0; d_vc[i] = 0; d_head[i] = 1'b0; d_tail[i] = 1'b0; d_flit[i] = '0;
        end
        cr_valid = 1'b0;
        cr_vc    = 0;
    endtask

    task automatic offer(input int i, input int vc, input bit h, input bit t, input logic [63:0] f);
        d_valid[i] = 1'b1; d_vc[i] = vc; d_head[i] = h; d_tail[i] = t; d_flit[i] = f;
    endtask

    task automatic apply();
        for (int i = 0; i < NUM_IN; i++) begin
            bus.in_valid[i]                = d_valid[i];
            bus.in_vc[i*VC_W +: VC_W]      = VC_W'(d_vc[i]);
            bus.in_head[i]                 = d_head[i];
            bus.in_tail[i]                 = d_tail[i];
            bus.in_flit[i*FLIT_W +: FLIT_W] = d_flit[i];
        end
        bus.credit_valid = cr_valid;
        bus.credit_vc    = VC_W'(cr_vc);
    endtask

    // Which input the rules grant this cycle, or -1.
    function automatic int m_pick();
        if (rst) return -1;
        for (int k = 0; k < NUM_IN; k++) begin
            int i = (m_rr + k) % NUM_IN;
            int v = d_vc[i];
            if (d_valid[i] && m_cnt[v] > 0 &&
                ((m_own[v] < 0 && d_head[i]) || m_own[v] == i))
                return i;
        end
        return -1;
    endfunction

    task automatic m_step(input int g);
        if (rst) begin
            for (int v = 0; v < CHANNELS; v++) begin m_cnt[v] = CREDITS; m_own[v] = -1; end
            m_rr = 0; m_err = 1'b0;
            e_valid = 1'b0; e_vc = 0; e_head = 1'b0; e_tail = 1'b0; e_flit = '0;
            return;
        end
        for (int i = 0; i < NUM_IN; i++) begin
            if (d_valid[i] && ((m_own[d_vc[i]] == i && d_head[i]) ||
                               (m_own[d_vc[i]] < 0 && !d_head[i])))
                m_err = 1'b1;
        end
        if (cr_valid && !(g >= 0 && d_vc[g] == cr_vc)) begin
            if (m_cnt[cr_vc] == CREDITS) m_err = 1'b1;
            else m_cnt[cr_vc]++;
        end
        if (g >= 0) begin
            int v = d_vc[g];
            if (!(cr_valid && cr_vc == v)) m_cnt[v]--;
            if (d_tail[g]) m_own[v] = -1;
            else if (m_own[v] < 0) m_own[v] = g;
            m_rr = (g + 1) % NUM_IN;
            e_valid = 1'b1; e_vc = v; e_head = d_head[g]; e_tail = d_tail[g]; e_flit = d_flit[g];
        end else begin
            e_valid = 1'b0;
        end
    endtask

    task automatic gen_random();
        for (int i = 0; i < NUM_IN; i++) begin
            if (p_left[i] == 0 && $urandom_range(0, 3) == 0) begin
                p_left[i]  = int'($urandom_range(1, 5));
                p_vc[i]    = int'($urandom_range(0, CHANNELS - 1));
                p_first[i] = 1'b1;
                p_flit[i]  = {$urandom, $urandom};
            end
            d_valid[i] = (p_left[i] > 0) && ($urandom_range(0, 7) != 0);
            d_vc[i]    = p_vc[i];
            d_head[i]  = p_first[i];
            d_tail[i]  = (p_left[i] == 1);
            d_flit[i]  = p_flit[i];
        end
        cr_valid = 1'b0;
        cr_vc    = int'($urandom_range(0, CHANNELS - 1));
        if (down_occ[cr_vc] > 0 && $urandom_range(0, 2) != 0) begin
            cr_valid = 1'b1;
            down_occ[cr_vc]--;
        end
    endtask

    task automatic advance(input int g);
        if (g >= 0) begin
            p_left[g]--;
            p_first[g] = 1'b0;
            p_flit[g]  = {$urandom, $urandom};
            down_occ[d_vc[g]]++;
        end
    endtask

    // One clock: drive at the falling edge, check grant, then check outputs.
    task automatic run_cycle();
        int g;
        logic [NUM_IN-1:0] exp_ready;
        @(negedge clk);
        if (rand_mode) gen_random();
        apply();
        #1;
        g = m_pick();
        exp_ready = (g >= 0) ? NUM_IN'(1) << g : '0;
        last_ready = bus.in_ready;
        check("in_ready", 64'(bus.in_ready), 64'(exp_ready));
        @(posedge clk);
        m_step(g);
        if (rand_mode && !rst) advance(g);
        #1;
        check("out_valid", 64'(bus.out_valid), 64'(e_valid));
        check("out_vc",    64'(bus.out_vc),    64'(e_vc));
        check("out_head",  64'(bus.out_head),  64'(e_head));
        check("out_tail",  64'(bus.out_tail),  64'(e_tail));
        check("out_flit",  bus.out_flit,       e_flit);
        check("proto_err", 64'(bus.proto_err), 64'(m_err));
    endtask

    task automatic do_reset();
        clr();
        rst = 1'b1;
        run_cycle();
        check("rst_ready", 64'(last_ready), 64'd0);
        rst = 1'b0;
    endtask

    initial begin
        clr();
        apply();
        do_reset();
        check("rst_ov", 64'(bus.out_valid), 64'd0);
        check("rst_err", 64'(bus.proto_err), 64'd0);

        // Single-flit packet, input 2, VC 1.
        offer(2, 1, 1'b1, 1'b1, 64'hA5A5_0001);
        run_cycle();
        check("sf_ready", 64'(last_ready), 64'd4);
        check("sf_ov", 64'(bus.out_valid), 64'd1);
        check("sf_vc", 64'(bus.out_vc), 64'd1);
        clr();
        offer(0, 1, 1'b1, 1'b0, 64'h11);
        run_cycle();
        check("sf_idle", 64'(last_ready), 64'd1);

        // Two heads on VC 0: input 0 wins and holds the lock until its tail.
        do_reset();
        offer(0, 0, 1'b1, 1'b0, 64'h100); offer(3, 0, 1'b1, 1'b0, 64'h300);
        run_cycle(); check("lk_c1", 64'(last_ready), 64'd1);
        offer(0, 0, 1'b0, 1'b1, 64'h101);
        run_cycle(); check("lk_c2", 64'(last_ready), 64'd1);
        d_valid[0] = 1'b0;
        run_cycle(); check("lk_c3", 64'(last_ready), 64'd8);
        offer(3, 0, 1'b0, 1'b1, 64'h301);
        run_cycle(); check("lk_c4", 64'(last_ready), 64'd8);

        // Credit exhaustion with a 5-flit packet; credit enables next cycle.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            offer(1, 0, k == 0, 1'b0, 64'(k));
            run_cycle(); check("cr_send", 64'(last_ready), 64'd2);
        end
        offer(1, 0, 1'b0, 1'b1, 64'h5);
        run_cycle(); check("cr_empty", 64'(last_ready), 64'd0);
        cr_valid = 1'b1; cr_vc = 0;
        run_cycle(); check("cr_same", 64'(last_ready), 64'd0);
        cr_valid = 1'b0;
        run_cycle(); check("cr_next", 64'(last_ready), 64'd2);

        // Simultaneous send and credit on VC 1 at cnt=2 keeps cnt at 2.
        do_reset();
        offer(0, 1, 1'b1, 1'b1, 64'h77);
        run_cycle(); run_cycle();
        cr_valid = 1'b1; cr_vc = 1;
        run_cycle(); check("sc_both", 64'(last_ready), 64'd1);
        cr_valid = 1'b0;
        run_cycle(); check("sc_rem1", 64'(last_ready), 64'd1);
        run_cycle(); check("sc_rem2", 64'(last_ready), 64'd1);
        run_cycle(); check("sc_out", 64'(last_ready), 64'd0);

        // Credit into a full VC: error flagged, count saturates.
        do_reset();
        cr_valid = 1'b1; cr_vc = 1;
        run_cycle();
        cr_valid = 1'b0;
        check("sat_err", 64'(bus.proto_err), 64'd1);
        offer(0, 1, 1'b1, 1'b1, 64'h88);
        for (int k = 0; k < 4; k++) begin
            run_cycle(); check("sat_send", 64'(last_ready), 64'd1);
        end
        run_cycle(); check("sat_full", 64'(last_ready), 64'd0);

        // Input 1 mid-packet on VC 0 interleaves with input 4 on VC 1.
        do_reset();
        offer(1, 0, 1'b1, 1'b0, 64'h1000);
        run_cycle(); check("il_c1", 64'(last_ready), 64'd2);
        offer(1, 0, 1'b0, 1'b0, 64'h1001); offer(4, 1, 1'b1, 1'b0, 64'h4000);
        run_cycle(); check("il_c2", 64'(last_ready), 64'd16);
        check("il_vc", 64'(bus.out_vc), 64'd1);
        offer(4, 1, 1'b0, 1'b1, 64'h4001);
        run_cycle(); check("il_c3", 64'(last_ready), 64'd2);
        run_cycle(); check("il_c4", 64'(last_ready), 64'd16);
        d_valid[4] = 1'b0; offer(1, 0, 1'b0, 1'b1, 64'h1002);
        run_cycle(); check("il_c5", 64'(last_ready), 64'd2);

        // Reset in the middle of a packet drops the lock.
        do_reset();
        offer(1, 0, 1'b1, 1'b0, 64'h2000);
        run_cycle();
        offer(1, 0, 1'b0, 1'b0, 64'h2001);
        rst = 1'b1;
        run_cycle(); check("mr_ready", 64'(last_ready), 64'd0);
        rst = 1'b0;
        check("mr_ov", 64'(bus.out_valid), 64'd0);
        check("mr_err", 64'(bus.proto_err), 64'd0);
        clr();
        offer(3, 0, 1'b1, 1'b1, 64'h3333);
        run_cycle(); check("mr_head", 64'(last_ready), 64'd8);

        // Protocol violations are never granted; other VCs keep flowing.
        do_reset();
        offer(2, 0, 1'b0, 1'b0, 64'h9);
        run_cycle(); check("pv_body", 64'(last_ready), 64'd0);
        check("pv_err1", 64'(bus.proto_err), 64'd1);
        do_reset();
        offer(0, 1, 1'b1, 1'b0, 64'hA);
        run_cycle(); check("pv_own1", 64'(last_ready), 64'd1);
        offer(3, 0, 1'b1, 1'b1, 64'hB);
        run_cycle(); check("pv_own2", 64'(last_ready), 64'd8);
        check("pv_err2", 64'(bus.proto_err), 64'd1);

        // Randomized legal traffic with a well-behaved downstream.
        do_reset();
        for (int i = 0; i < NUM_IN; i++) begin
            p_left[i] = 0; p_vc[i] = 0; p_first[i] = 1'b0; p_flit[i] = '0;
        end
        for (int v = 0; v < CHANNELS; v++) down_occ[v] = 0;
        rand_mode = 1'b1;
        repeat (3000) run_cycle();
        rand_mode = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
